packet_transmitter: RTL

- Transmit-side counterpart of the packet checker. Collects NUMBER_OF_WORD payload words from an upstream ready/valid source into a local buffer.
- Emits each collected packet as a framed stream on packet_data_out, with start_of_packet, end_of_packet and data_valid, and honours downstream backpressure via tx_ready.
- Counts packets sent, saturating at MAX_COUNT; feeds the checker directly in loopback benches.

---
 rtl/pkt_pkg.sv | 21 ++
 rtl/pkt_sat_counter.sv | 25 ++
 rtl/packet_transmitter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_pkg.sv
// Shared constants, count-width helper and FSM state type for the packet
// transmitter / checker pair.
package pkt_pkg;

    localparam int unsigned DEF_PACKET_WIDTH   = 32;
    localparam int unsigned DEF_NUMBER_OF_WORD = 5;
    localparam int unsigned DEF_MAX_COUNT      = 15;
    localparam int unsigned DEF_IDLE_GAP       = 1;

    // Width of every saturating counter in the packet blocks.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } pkt_state_t;

endpackage

// File: rtl/pkt_sat_counter.sv
// Saturating up-counter with increment enable; holds at MAX_COUNT.
module pkt_sat_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled increments until the saturation value is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != WIDTH'(MAX_COUNT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/packet_transmitter.sv
// Packet transmitter: buffers NUMBER_OF_WORD upstream words, then sends them
// as a framed stream (SOP/EOP/valid) with downstream backpressure, followed
// by IDLE_GAP idle cycles. Counts sent packets with saturation.
// Optional build macro PKT_TX_ERR_INJECT_EN adds err_inject_req, which
// truncates the next packet by one word (EOP moved to the second-last word)
// and counts such packets in packet_err_injected_counter.
module packet_transmitter
    import pkt_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH   = DEF_PACKET_WIDTH,
    parameter int unsigned NUMBER_OF_WORD = DEF_NUMBER_OF_WORD,
    parameter int unsigned MAX_COUNT      = DEF_MAX_COUNT,
    parameter int unsigned IDLE_GAP       = DEF_IDLE_GAP
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               word_in_valid,
    input  logic [PACKET_WIDTH-1:0]            word_in_data,
    output logic                               word_in_ready,
    input  logic                               tx_ready,
    output logic                               data_valid,
    output logic [PACKET_WIDTH-1:0]            packet_data_out,
    output logic                               start_of_packet,
    output logic                               end_of_packet,
    output logic                               packet_sent_flag,
    output logic [cnt_width(MAX_COUNT)-1:0]    packet_sent_counter
`ifdef PKT_TX_ERR_INJECT_EN
    ,
    input  logic                               err_inject_req,
    output logic [cnt_width(MAX_COUNT)-1:0]    packet_err_injected_counter
`endif
);

    localparam int unsigned CW        = cnt_width(MAX_COUNT);
    localparam logic [2:0]  LAST_IDX  = 3'(NUMBER_OF_WORD - 1);
    localparam logic [2:0]  SHORT_IDX = 3'(NUMBER_OF_WORD - 2);
    localparam logic [2:0]  GAP_LAST  = 3'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

    pkt_state_t              r_state;
    pkt_state_t              w_next_state;
    logic [2:0]              r_wr_idx;
    logic [2:0]              r_rd_idx;
    logic [2:0]              r_gap_cnt;
    logic [PACKET_WIDTH-1:0] r_buf [NUMBER_OF_WORD];

    logic                    r_word_in_ready;
    logic                    r_data_valid;
    logic [PACKET_WIDTH-1:0] r_data;
    logic                    r_sop;
    logic                    r_eop;
    logic                    r_sent_flag;

    logic                    w_accept;
    logic                    w_last_accept;
    logic                    w_eop_xfer;
    logic [2:0]              w_rd_next;
    logic                    w_first_eop;
    logic                    w_next_eop;
    logic                    w_armed_now;   // arming seen so far for the packet being filled
    logic                    w_pkt_armed;   // arming of the packet currently being sent
    logic                    w_sent_inc;
    logic                    w_err_inc;

`ifdef PKT_TX_ERR_INJECT_EN
    logic r_armed;

    assign w_armed_now = r_armed || ((r_state == FILL) && err_inject_req);
    assign w_pkt_armed = r_armed;

    // Latch an injection request seen during FILL; cleared on re-entering FILL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed <= 1'b0;
        end else if ((r_state != FILL) && (w_next_state == FILL)) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= w_armed_now;
        end
    end
`else
    assign w_armed_now = 1'b0;
    assign w_pkt_armed = 1'b0;
`endif

    assign w_rd_next   = r_rd_idx + 3'd1;
    assign w_first_eop = ((w_armed_now ? SHORT_IDX : LAST_IDX) == 3'd0);
    assign w_next_eop  = (w_rd_next == (w_pkt_armed ? SHORT_IDX : LAST_IDX));
    assign w_sent_inc  = w_eop_xfer && !w_pkt_armed;
    assign w_err_inc   = w_eop_xfer && w_pkt_armed;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake qualifiers.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_last_accept = 1'b0;
        w_eop_xfer    = 1'b0;
        case (r_state)
            FILL: begin
                w_accept      = word_in_valid && r_word_in_ready;
                w_last_accept = w_accept && (r_wr_idx == LAST_IDX);
                if (w_last_accept) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                w_eop_xfer = r_data_valid && tx_ready && r_eop;
                if (w_eop_xfer) begin
                    w_next_state = (IDLE_GAP == 0) ? FILL : GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = FILL;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    // Ready is registered, so it only rises after a full cycle spent in FILL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_in_ready <= 1'b0;
        end else begin
            r_word_in_ready <= (r_state == FILL) && (w_next_state == FILL);
        end
    end

    // Write index and idle-gap counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_idx  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_last_accept) begin
                r_wr_idx <= '0;
            end else if (w_accept) begin
                r_wr_idx <= r_wr_idx + 3'd1;
            end
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 3'd1 : 3'd0;
        end
    end

    // Payload buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_idx] <= word_in_data;
        end
    end

    // Output word registers: load word 0 on the last fill beat, advance on each
    // transfer, clear after the EOP transfer; hold while tx_ready is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_rd_idx     <= '0;
            r_sent_flag  <= 1'b0;
        end else begin
            r_sent_flag <= w_eop_xfer;
            if (w_last_accept) begin
                r_data_valid <= 1'b1;
                r_data       <= r_buf[0];
                r_sop        <= 1'b1;
                r_eop        <= w_first_eop;
                r_rd_idx     <= '0;
            end else if ((r_state == SEND) && tx_ready) begin
                if (r_eop) begin
                    r_data_valid <= 1'b0;
                    r_data       <= '0;
                    r_sop        <= 1'b0;
                    r_eop        <= 1'b0;
                    r_rd_idx     <= '0;
                end else begin
                    r_data   <= r_buf[w_rd_next];
                    r_sop    <= 1'b0;
                    r_eop    <= w_next_eop;
                    r_rd_idx <= w_rd_next;
                end
            end
        end
    end

    pkt_sat_counter #(
        .WIDTH     (CW),
        .MAX_COUNT (MAX_COUNT)
    ) u_sent_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_sent_inc),
        .o_count (packet_sent_counter)
    );

`ifdef PKT_TX_ERR_INJECT_EN
    pkt_sat_counter #(
        .WIDTH     (CW),
        .MAX_COUNT (MAX_COUNT)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_err_inc),
        .o_count (packet_err_injected_counter)
    );
`else
    logic w_unused_err;
    assign w_unused_err = w_err_inc;
`endif

    assign word_in_ready    = r_word_in_ready;
    assign data_valid       = r_data_valid;
    assign packet_data_out  = r_data;
    assign start_of_packet  = r_sop;
    assign end_of_packet    = r_eop;
    assign packet_sent_flag = r_sent_flag;

endmodule
